// File: rtl/mux_scan_n.sv
// Time-multiplexed N-to-1 channel scanner for the seven-segment display path.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module mux_scan_n #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 4,
    parameter int DIV      = 50000,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] Din,
    output logic [WIDTH-1:0]          Dout,
    output logic [SEL_W-1:0]          S,
    output logic [CHANNELS-1:0]       anode,
    output logic                      frame_done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    LAST_COUNT = PW'(DIV - 1);
    localparam logic [SEL_W-1:0] LAST_INDEX = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        BLANKED,
        SCANNING
    } mode_t;

    mode_t                     mode;
    mode_t                     modeNext;
    logic [PW-1:0]             prescaler;
    logic [PW-1:0]             prescalerNext;
    logic [SEL_W-1:0]          index;
    logic [SEL_W-1:0]          indexNext;
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic [CHANNELS*WIDTH-1:0] src;
    logic [WIDTH-1:0]          srcSlice;
    logic [CHANNELS-1:0]       anodeNext;
    logic                      tick;
    logic                      wrap;
    logic                      load;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode <= BLANKED;
        end else begin
            mode <= modeNext;
        end
    end

    // Leaving BLANKED reloads the outputs at once; while scanning only a tick does.
    always_comb begin
        modeNext = mode;
        load     = 1'b0;
        case (mode)
            BLANKED: begin
                if (enable) begin
                    modeNext = SCANNING;
                    load     = 1'b1;
                end
            end
            SCANNING: begin
                if (!enable) begin
                    modeNext = BLANKED;
                end else begin
                    load = tick;
                end
            end
            default: begin
                modeNext = BLANKED;
            end
        endcase
    end

    always_comb begin
        tick          = enable && (prescaler == LAST_COUNT);
        wrap          = tick && (index == LAST_INDEX);
        prescalerNext = tick ? '0 : prescaler + PW'(1);
        if (wrap) begin
            indexNext = '0;
        end else if (tick) begin
            indexNext = index + SEL_W'(1);
        end else begin
            indexNext = index;
        end
        // The shadow loads on the wrap edge itself, so that edge reads Din directly.
        src      = wrap ? Din : shadow;
        srcSlice = src[indexNext*WIDTH +: WIDTH];
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [CHANNELS-1:0] upperZero;

    always_comb begin
        upperZero[CHANNELS-1] = (src[(CHANNELS-1)*WIDTH +: WIDTH] == '0);
        for (int k = CHANNELS - 2; k >= 0; k--) begin
            upperZero[k] = upperZero[k+1] && (src[k*WIDTH +: WIDTH] == '0);
        end
        for (int k = 0; k < CHANNELS; k++) begin
            anodeNext[k] = (indexNext != SEL_W'(k)) || ((k >= 1) && upperZero[k]);
        end
    end
`else
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            anodeNext[k] = (indexNext != SEL_W'(k));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler <= '0;
            index     <= '0;
        end else if (enable) begin
            prescaler <= prescalerNext;
            index     <= indexNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (!enable || wrap) begin
            shadow <= Din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Dout       <= '0;
            S          <= '0;
            anode      <= '1;
            frame_done <= 1'b0;
        end else if (!enable) begin
            anode      <= '1;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                S     <= indexNext;
                Dout  <= srcSlice;
                anode <= anodeNext;
            end
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n: a frame-level behavioural model checked every
// cycle, plus directed literal expectations. Define LEADING_ZERO_BLANK_EN to test blanking.
module tb_mux_scan_n;

    localparam int CH = 8;
    localparam int W  = 4;
    localparam int DV = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] Din;
    logic [3:0]  Dout;
    logic [2:0]  S;
    logic [7:0]  anode;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_n #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .DIV     (DV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .Din       (Din),
        .Dout      (Dout),
        .S         (S),
        .anode     (anode),
        .frame_done(frame_done)
    );

    int          mCnt;
    int          mIdx;
    logic [31:0] mShadow;
    logic        mRun;
    logic        modelValid = 1'b0;
    logic [3:0]  eDout;
    logic [2:0]  eS;
    logic [7:0]  eAnode;
    logic        eFd;

    function automatic logic [3:0] digitOf(input logic [31:0] word, input int k);
        logic [31:0] shifted;
        shifted = word >> (4 * k);
        return shifted[3:0];
    endfunction

    // Display rule: one digit lit; optionally digits above the highest nonzero one stay dark.
    function automatic logic [7:0] anodeFor(input int idx, input logic [31:0] word);
        logic [7:0] a;
        int         highest;
        a       = ~(8'h01 << idx);
        highest = 0;
        for (int k = 0; k < CH; k++) begin
            if (digitOf(word, k) != 4'h0) highest = k;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 1; k < CH; k++) begin
            if (k > highest) a[k] = 1'b1;
        end
`endif
        return a;
    endfunction

    always @(posedge clk) begin
        int          nIdx;
        logic        slotEnd;
        logic        frameEnd;
        logic [31:0] word;
        if (!reset_n) begin
            mCnt       <= 0;
            mIdx       <= 0;
            mShadow    <= 32'h0;
            mRun       <= 1'b0;
            eDout      <= 4'h0;
            eS         <= 3'd0;
            eAnode     <= 8'hFF;
            eFd        <= 1'b0;
            modelValid <= 1'b1;
        end else if (enable) begin
            slotEnd  = (mCnt == DV - 1);
            frameEnd = slotEnd && (mIdx == CH - 1);
            nIdx     = slotEnd ? (mIdx + 1) % CH : mIdx;
            word     = frameEnd ? Din : mShadow;
            mCnt     <= (mCnt + 1) % DV;
            mIdx     <= nIdx;
            if (frameEnd) mShadow <= Din;
            if (slotEnd || !mRun) begin
                eS     <= 3'(nIdx);
                eDout  <= digitOf(word, nIdx);
                eAnode <= anodeFor(nIdx, word);
            end
            eFd  <= frameEnd;
            mRun <= 1'b1;
        end else begin
            mShadow <= Din;
            eAnode  <= 8'hFF;
            eFd     <= 1'b0;
            mRun    <= 1'b0;
        end
    end

    task automatic compareField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            compareField("model_dout", 32'(Dout), 32'(eDout));
            compareField("model_s", 32'(S), 32'(eS));
            compareField("model_anode", 32'(anode), 32'(eAnode));
            compareField("model_frame_done", 32'(frame_done), 32'(eFd));
        end
    end

    // Inputs change at a falling edge and are held for the given number of rising edges.
    task automatic applyStimulus(input logic rn, input logic en, input logic [31:0] d, input int edges);
        reset_n = rn;
        enable  = en;
        Din     = d;
        repeat (edges) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] d, input logic [2:0] s,
                               input logic [7:0] a, input logic f);
        compareField({name, "_dout"}, 32'(Dout), 32'(d));
        compareField({name, "_s"}, 32'(S), 32'(s));
        compareField({name, "_anode"}, 32'(anode), 32'(a));
        compareField({name, "_frame_done"}, 32'(frame_done), 32'(f));
    endtask

    logic [31:0] din;
    logic [7:0]  blankS3;
    logic [7:0]  blankS1;

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        blankS3 = 8'hFF;
        blankS1 = 8'hFF;
`else
        blankS3 = 8'hF7;
        blankS1 = 8'hFD;
`endif
        reset_n = 1'b0;
        enable  = 1'b1;
        Din     = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset", 4'h0, 3'd0, 8'hFF, 1'b0);
        end

        applyStimulus(1'b1, 1'b1, 32'h87654321, 1);
        checkOutput("release", 4'h0, 3'd0, 8'hFE, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 31);
        checkOutput("first_wrap", 4'h1, 3'd0, 8'hFE, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 1);
        checkOutput("pulse_end", 4'h1, 3'd0, 8'hFE, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 3);
        checkOutput("scan_s1", 4'h2, 3'd1, 8'hFD, 1'b0);

        din = 32'h87654321;
        for (int k = 2; k < CH; k++) begin
            applyStimulus(1'b1, 1'b1, din, 4);
            checkOutput($sformatf("scan_s%0d", k), 4'(k + 1), 3'(k), ~(8'h01 << k), 1'b0);
            if (k == 3) din = 32'hFFFFFFFF;
        end
        applyStimulus(1'b1, 1'b1, din, 4);
        checkOutput("tearfree_wrap", 4'hF, 3'd0, 8'hFE, 1'b1);
        applyStimulus(1'b1, 1'b1, din, 20);
        checkOutput("before_drop", 4'hF, 3'd5, 8'hDF, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h87654321, 1);
        checkOutput("drop_first", 4'hF, 3'd5, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h87654321, 9);
        checkOutput("drop_last", 4'hF, 3'd5, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 1);
        checkOutput("reenable", 4'h6, 3'd5, 8'hDF, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 2);
        checkOutput("reenable_hold", 4'h6, 3'd5, 8'hDF, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 1);
        checkOutput("reenable_s6", 4'h7, 3'd6, 8'hBF, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h87654321, 1);
        checkOutput("midframe_reset", 4'h0, 3'd0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 1);
        checkOutput("restart", 4'h0, 3'd0, 8'hFE, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h87654321, 31);
        checkOutput("restart_wrap", 4'h1, 3'd0, 8'hFE, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h00000305, 1);
        checkOutput("lz_load", 4'h1, 3'd0, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h00000305, 1);
        checkOutput("lz_s0", 4'h5, 3'd0, 8'hFE, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h00000305, 3);
        checkOutput("lz_s1", 4'h0, 3'd1, 8'hFD, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h00000305, 4);
        checkOutput("lz_s2", 4'h3, 3'd2, 8'hFB, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h00000305, 4);
        checkOutput("lz_s3", 4'h0, 3'd3, blankS3, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h00000000, 1);
        checkOutput("zero_load", 4'h0, 3'd3, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h00000000, 1);
        checkOutput("zero_s3", 4'h0, 3'd3, blankS3, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h00000000, 19);
        checkOutput("zero_s0", 4'h0, 3'd0, 8'hFE, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h00000000, 4);
        checkOutput("zero_s1", 4'h0, 3'd1, blankS1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
